gcd_stein_seq: RTL and testbench

- Parametrised, multi-cycle binary (Stein) GCD engine with a start/done handshake.
- Performs one shift or subtract step per clock, so the datapath stays narrow and timing-friendly.
- Operands use the full WIDTH bits, including the MSB.
- Sits behind control logic as a reusable arithmetic unit. One operation in flight at a time.

---
 rtl/gcd_stein_seq.sv | 141 ++++++++++++++
 tb/tb_gcd_stein_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gcd_stein_seq.sv
// gcd_stein_seq: multi-cycle binary (Stein) GCD engine with start/done handshake.
// One shift or subtract per clock. One operation in flight at a time.
// Optional build macro GCD_STEIN_CYCLE_COUNT_EN adds a saturating 16-bit
// 'cycles' output reporting the latency of the last operation.
`timescale 1ns/1ps
module gcd_stein_seq #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef GCD_STEIN_CYCLE_COUNT_EN
    ,
    output logic [15:0]      cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE, CHECK, COMMON, ODD_A, REDUCE, DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] ra, rb, ra_n, rb_n, result_n;
    logic [KW-1:0]    k, k_n;

    // Handshake outputs decode straight from the state register (glitch-free).
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            k      <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            ra     <= ra_n;
            rb     <= rb_n;
            k      <= k_n;
            result <= result_n;
        end
    end

    // Next-state and datapath step: exactly one shift or subtract per cycle.
    always_comb begin
        state_n  = state;
        ra_n     = ra;
        rb_n     = rb;
        k_n      = k;
        result_n = result;
        case (state)
            IDLE: begin
                if (start) begin
                    ra_n    = a;
                    rb_n    = b;
                    k_n     = '0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                // A zero operand short-circuits: gcd(0,x)=x, and gcd(0,0)=0.
                if (ra == '0) begin
                    result_n = rb;
                    state_n  = DONE;
                end else if (rb == '0) begin
                    result_n = ra;
                    state_n  = DONE;
                end else begin
                    state_n = COMMON;
                end
            end
            COMMON: begin
                // Strip the shared power of two; k remembers how many.
                if (!(ra[0] | rb[0])) begin
                    ra_n = ra >> 1;
                    rb_n = rb >> 1;
                    k_n  = k + KW'(1);
                end else begin
                    state_n = ODD_A;
                end
            end
            ODD_A: begin
                // Make ra odd; it stays odd for the rest of the reduction.
                if (!ra[0]) ra_n = ra >> 1;
                else        state_n = REDUCE;
            end
            REDUCE: begin
                if (rb == '0) begin
                    // Result fits in WIDTH since it never exceeds min(a,b).
                    result_n = ra << k;
                    state_n  = DONE;
                end else if (!rb[0]) begin
                    rb_n = rb >> 1;
                end else if (ra < rb) begin
                    rb_n = rb - ra;
                end else begin
                    ra_n = rb;
                    rb_n = ra - rb;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef GCD_STEIN_CYCLE_COUNT_EN
    logic [15:0] cnt;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt == 16'hFFFF) ? 16'hFFFF : cnt + 16'd1;

    // Latency counter: edges from the accepting edge through DONE entry, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            cycles <= '0;
        end else begin
            if (state == IDLE) begin
                if (start) cnt <= 16'd1;
            end else if (state != DONE) begin
                cnt <= cnt_inc;
            end
            if (state_n == DONE && state != DONE) cycles <= cnt_inc;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_stein_seq.sv
// tb_gcd_stein_seq: directed vectors with hand-computed GCDs for WIDTH=8 and WIDTH=16.
`timescale 1ns/1ps
module tb_gcd_stein_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, result8;
    logic [15:0] a16 = '0, b16 = '0, result16;
    logic        busy8, done8, busy16, done16;
`ifdef GCD_STEIN_CYCLE_COUNT_EN
    logic [15:0] cycles8, cycles16;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_done8 = 0;
    int lat;
    int d0;

    always #5 clk = ~clk;

    gcd_stein_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8)
`ifdef GCD_STEIN_CYCLE_COUNT_EN
        , .cycles(cycles8)
`endif
    );

    gcd_stein_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16)
`ifdef GCD_STEIN_CYCLE_COUNT_EN
        , .cycles(cycles16)
`endif
    );

    // Count done pulses of the 8-bit engine.
    always @(posedge clk) if (done8) n_done8 <= n_done8 + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one 8-bit operation; returns with done high, lat = cycle index of done.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, output int l);
        @(negedge clk); start8 = 1'b1; a8 = x; b8 = y;
        @(posedge clk); #1; start8 = 1'b0; l = 1;
        while (!done8 && l < 200) begin @(posedge clk); #1; l++; end
        if (!done8) chk("timeout8", 32'd0, 32'd1);
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, output int l);
        @(negedge clk); start16 = 1'b1; a16 = x; b16 = y;
        @(posedge clk); #1; start16 = 1'b0; l = 1;
        while (!done16 && l < 400) begin @(posedge clk); #1; l++; end
        if (!done16) chk("timeout16", 32'd0, 32'd1);
    endtask

    // Full 8-bit vector: result at done, then idle on the following cycle.
    task automatic vec8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp);
        int l;
        op8(x, y, l);
        chk(tag, 32'(result8), 32'(exp));
        chk("lat_bound8", 32'(l <= 36), 32'd1);
        @(posedge clk); #1;
        chk("busy_after8", 32'(busy8), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_result", 32'(result8), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Basic operation
        op8(8'd48, 8'd18, lat);
        chk("g48_18", 32'(result8), 32'd6);
        chk("busy_at_done", 32'(busy8), 32'd1);
        @(posedge clk); #1;
        chk("busy_after", 32'(busy8), 32'd0);
        chk("done_pulse", 32'(done8), 32'd0);

        // Zero operands: done in 2nd cycle after accept
        op8(8'd0, 8'd37, lat);
        chk("g0_37", 32'(result8), 32'd37);
        chk("lat_zero", 32'(lat), 32'd2);
        @(posedge clk); #1;
        vec8("g37_0", 8'd37, 8'd0, 8'd37);
        vec8("g0_0", 8'd0, 8'd0, 8'd0);
        vec8("g128_64", 8'd128, 8'd64, 8'd64);
        vec8("g255_255", 8'd255, 8'd255, 8'd255);
        vec8("g255_254", 8'd255, 8'd254, 8'd1);
        vec8("g200_150", 8'd200, 8'd150, 8'd50);

        // Start while busy is ignored
        d0 = n_done8;
        @(negedge clk); start8 = 1'b1; a8 = 8'd48; b8 = 8'd18;
        @(negedge clk); start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd6;
        @(negedge clk); start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("ignore_busy", 32'(result8), 32'd6);
        @(posedge clk); #1;
        chk("one_done", 32'(n_done8 - d0), 32'd1);
        repeat (10) @(posedge clk); #1;
        chk("no_queue", 32'(n_done8 - d0), 32'd1);
        vec8("g9_6", 8'd9, 8'd6, 8'd3);

        // Reset mid-REDUCE aborts the operation
        @(negedge clk); start8 = 1'b1; a8 = 8'd200; b8 = 8'd150;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (7) @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy8), 32'd1);
        reset = 1'b1; #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_result", 32'(result8), 32'd0);
        d0 = n_done8;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("no_done_after_rst", 32'(n_done8 - d0), 32'd0);
        vec8("g200_150_again", 8'd200, 8'd150, 8'd50);

        // WIDTH=16
        op16(16'd65520, 16'd48, lat);
        chk("g65520_48", 32'(result16), 32'd48);
        chk("lat_bound16", 32'(lat <= 68), 32'd1);
`ifdef GCD_STEIN_CYCLE_COUNT_EN
        chk("cyc_nz", 32'(cycles16 != 16'd0), 32'd1);
        chk("cyc_max", 32'(cycles16 <= 16'd68), 32'd1);
        chk("cyc_lat", 32'(cycles16), 32'(lat));
`endif
        @(posedge clk); #1;
        chk("busy_after16", 32'(busy16), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
